// File: rtl/kb_led_sequencer.sv
// kb_led_sequencer
// Mirrors a lock-key status vector onto PS/2 keyboard indicator LEDs.
// When the status changes, the block waits a settle interval and then sends
// the "set LEDs" command (0xED) followed by the LED mask byte. After each byte
// it waits for an ACK (0xFA). A resend request (0xFE) or an ACK timeout causes
// the byte to be retransmitted, up to MAX_RETRY times per byte.
//
// Transmit handshake: send_req is a registered request. tx_data is stable from
// the first SEND cycle up to and including the cycle in which send_req and
// tx_ready are both high. That cycle transfers the byte, and send_req is low in
// the following cycle.
module kb_led_sequencer #(
    parameter int NUM_LEDS  = 3,
    parameter int DELAY_W   = 20,
    parameter int ACK_TO_W  = 20,
    parameter int MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] status,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                send_req,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                busy,
    output logic                err,
    output logic [NUM_LEDS-1:0] leds_applied
);

    // One shared counter covers both the settle interval and the ACK timeout.
    localparam int CNT_W = (DELAY_W > ACK_TO_W) ? DELAY_W : ACK_TO_W;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((64'd1 << DELAY_W) - 64'd1);
    localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'((64'd1 << ACK_TO_W) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        SEND_CMD = 3'd2,
        ACK_CMD  = 3'd3,
        SEND_ARG = 3'd4,
        ACK_ARG  = 3'd5
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [NUM_LEDS-1:0]  prev_status;
    logic                 pending;
    logic                 pending_next;
    logic [NUM_LEDS-1:0]  snap;
    logic [NUM_LEDS-1:0]  snap_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [3:0]           retry;
    logic [3:0]           retry_next;
    logic [NUM_LEDS-1:0]  leds_next;
    logic                 err_next;
    logic                 send_req_next;
    logic [7:0]           tx_data_next;

    logic                 chg;
    logic                 got_ack;
    logic                 got_resend;
    logic                 ack_timeout;
    logic                 tx_accept;

    assign chg         = (status != prev_status);
    assign got_ack     = rx_valid && (rx_data == RSP_ACK);
    assign got_resend  = rx_valid && (rx_data == RSP_RESEND);
    assign ack_timeout = (cnt == ACK_LAST);
    assign tx_accept   = send_req && tx_ready;
    assign busy        = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus next values for all datapath registers.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        snap_next    = snap;
        cnt_next     = cnt;
        retry_next   = retry;
        leds_next    = leds_applied;
        err_next     = 1'b0;

        // A change while busy is remembered so the sequence runs again once
        // the current transaction (with its old snapshot) has finished.
        if ((state != IDLE) && chg) begin
            pending_next = 1'b1;
        end

        case (state)
            IDLE: begin
                cnt_next   = '0;
                retry_next = '0;
                if (chg || pending) begin
                    pending_next = 1'b0;
                    state_next   = SETTLE;
                end
            end

            SETTLE: begin
                // Changes during settle do not restart the count; the latest
                // status is captured when the interval ends.
                if (cnt == SETTLE_LAST) begin
                    snap_next  = status;
                    cnt_next   = '0;
                    state_next = SEND_CMD;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            SEND_CMD: begin
                cnt_next = '0;
                if (tx_accept) begin
                    state_next = ACK_CMD;
                end
            end

            SEND_ARG: begin
                cnt_next = '0;
                if (tx_accept) begin
                    state_next = ACK_ARG;
                end
            end

            ACK_CMD, ACK_ARG: begin
                // Unrelated received bytes fall through and leave cnt running.
                cnt_next = cnt + CNT_ONE;
                if (got_ack) begin
                    // ACK wins over a timeout in the same cycle.
                    cnt_next   = '0;
                    retry_next = '0;
                    if (state == ACK_CMD) begin
                        state_next = SEND_ARG;
                    end else begin
                        leds_next  = snap;
                        state_next = IDLE;
                    end
                end else if (got_resend || ack_timeout) begin
                    cnt_next = '0;
                    if (retry < RETRY_LIMIT) begin
                        retry_next = retry + 4'd1;
                        state_next = (state == ACK_CMD) ? SEND_CMD : SEND_ARG;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Transmit outputs are registered from the upcoming state so they are
        // valid on the very first SEND cycle and drop right after acceptance.
        send_req_next = (state_next == SEND_CMD) || (state_next == SEND_ARG);
        tx_data_next  = (state_next == SEND_ARG) ? 8'(snap_next) : CMD_SET_LEDS;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_status  <= '0;
            pending      <= 1'b0;
            snap         <= '0;
            cnt          <= '0;
            retry        <= '0;
            leds_applied <= '0;
            err          <= 1'b0;
            send_req     <= 1'b0;
            tx_data      <= CMD_SET_LEDS;
        end else begin
            prev_status  <= status;
            pending      <= pending_next;
            snap         <= snap_next;
            cnt          <= cnt_next;
            retry        <= retry_next;
            leds_applied <= leds_next;
            err          <= err_next;
            send_req     <= send_req_next;
            tx_data      <= tx_data_next;
        end
    end

endmodule

// File: tb/tb_kb_led_sequencer.sv
// Testbench for kb_led_sequencer (NUM_LEDS=3, DELAY_W=4, ACK_TO_W=5, MAX_RETRY=2).
// Every transmitted byte is popped from an expected-byte queue at acceptance.
module tb_kb_led_sequencer;

    logic       clk;
    logic       reset;
    logic [2:0] status;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       send_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       err;
    logic [2:0] leds_applied;

    kb_led_sequencer #(
        .NUM_LEDS (3),
        .DELAY_W  (4),
        .ACK_TO_W (5),
        .MAX_RETRY(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .status      (status),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .send_req    (send_req),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .err         (err),
        .leds_applied(leds_applied)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [7:0] arg;
        logic [2:0] leds;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_cnt  = 0;
    bit acc_flag = 0;
    int acc_cyc  = 0;
    int acc_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: scoreboard sampling at the falling edge, then advance
    // to just after the next rising edge where stimulus is driven.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (err) err_cnt++;
        if (send_req && tx_ready) begin
            acc_flag = 1;
            acc_prev = acc_cyc;
            acc_cyc  = cyc;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_tx: unexpected byte 0x%02h with empty expected queue", tx_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_tx", {24'd0, tx_data}, {24'd0, e});
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_accept(input string name, input int budget);
        acc_flag = 0;
        for (int k = 0; k < budget && !acc_flag; k++) tick();
        if (!acc_flag) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no byte accepted within %0d cycles, got none, expected one", name, budget);
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Full transaction with immediate ACKs for both bytes.
    task automatic run_txn(input string name, input logic [2:0] st, input logic [7:0] arg);
        status = st;
        exp_q.push_back(8'hED);
        exp_q.push_back(arg);
        wait_accept({name, "_cmd"}, 40);
        rx_byte(8'hFA);
        wait_accept({name, "_arg"}, 10);
        rx_byte(8'hFA);
    endtask

    initial begin
        vecs[0] = '{st: 3'd3, arg: 8'h03, leds: 3'd3};
        vecs[1] = '{st: 3'd0, arg: 8'h00, leds: 3'd0};
        vecs[2] = '{st: 3'd6, arg: 8'h06, leds: 3'd6};
        vecs[3] = '{st: 3'd1, arg: 8'h01, leds: 3'd1};
        vecs[4] = '{st: 3'd7, arg: 8'h07, leds: 3'd7};

        reset    = 1'b1;
        status   = 3'd0;
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();

        // Reset state
        check("rst_send_req", {31'd0, send_req}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'hED);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_leds", {29'd0, leds_applied}, 32'd0);

        // Scenario 1: status 0->3 at cycle 10, command at cycle 27
        reset = 1'b0;
        repeat (10) tick();
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        status = 3'd3;
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h03);
        repeat (16) tick();
        check("t1_req_c26", {31'd0, send_req}, 32'd0);
        check("t1_busy_settle", {31'd0, busy}, 32'd1);
        tick();
        check("t1_req_c27", {31'd0, send_req}, 32'd1);
        check("t1_data_c27", {24'd0, tx_data}, 32'hED);
        wait_accept("t1_cmd", 5);
        check("t1_req_drop", {31'd0, send_req}, 32'd0);
        rx_byte(8'hFA);
        check("t1_arg_req", {31'd0, send_req}, 32'd1);
        check("t1_arg_data", {24'd0, tx_data}, 32'h03);
        wait_accept("t1_arg", 5);
        rx_byte(8'hFA);
        check("t1_leds", {29'd0, leds_applied}, 32'd3);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_err_cnt", err_cnt, 0);

        // Scenario 2: two resend requests on the command byte, then ACK
        status = 3'd2;
        exp_q.push_back(8'hED);
        exp_q.push_back(8'hED);
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h02);
        wait_accept("t2_cmd0", 40);
        rx_byte(8'hFE);
        wait_accept("t2_cmd1", 5);
        rx_byte(8'hFE);
        wait_accept("t2_cmd2", 5);
        rx_byte(8'hFA);
        wait_accept("t2_arg", 5);
        rx_byte(8'hFA);
        check("t2_leds", {29'd0, leds_applied}, 32'd2);
        check("t2_err_cnt", err_cnt, 0);

        // Scenario 3: argument never acknowledged -> 3 attempts then err
        status = 3'd5;
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h05);
        wait_accept("t3_cmd", 40);
        rx_byte(8'hFA);
        wait_accept("t3_arg0", 5);
        wait_accept("t3_arg1", 40);
        check("t3_gap1", acc_cyc - acc_prev, 33);
        wait_accept("t3_arg2", 40);
        check("t3_gap2", acc_cyc - acc_prev, 33);
        repeat (31) tick();
        check("t3_err_early", {31'd0, err}, 32'd0);
        check("t3_busy_wait", {31'd0, busy}, 32'd1);
        tick();
        check("t3_err_pulse", {31'd0, err}, 32'd1);
        check("t3_busy_idle", {31'd0, busy}, 32'd0);
        check("t3_leds_kept", {29'd0, leds_applied}, 32'd2);
        tick();
        check("t3_err_drop", {31'd0, err}, 32'd0);
        check("t3_err_cnt", err_cnt, 1);
        repeat (3) tick();
        check("t3_stays_idle", {31'd0, busy}, 32'd0);

        // Scenario 4: status change while ACK_CMD pending
        status = 3'd1;
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h01);
        wait_accept("t4_cmd", 40);
        status = 3'd6;
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h06);
        rx_byte(8'hFA);
        wait_accept("t4_arg_old", 5);
        rx_byte(8'hFA);
        check("t4_leds_old", {29'd0, leds_applied}, 32'd1);
        check("t4_idle", {31'd0, busy}, 32'd0);
        tick();
        check("t4_resettle", {31'd0, busy}, 32'd1);
        wait_accept("t4_cmd_new", 40);
        rx_byte(8'hFA);
        wait_accept("t4_arg_new", 5);
        rx_byte(8'hFA);
        check("t4_leds_new", {29'd0, leds_applied}, 32'd6);

        // Scenario 5: transmitter stall, then a stray scan code in ACK_ARG
        status   = 3'd4;
        tx_ready = 1'b0;
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h04);
        for (int k = 0; k < 40 && !send_req; k++) tick();
        check("t5_req_up", {31'd0, send_req}, 32'd1);
        for (int k = 0; k < 50; k++) begin
            tick();
            if (send_req !== 1'b1 || tx_data !== 8'hED) begin
                check("t5_stall_hold", {23'd0, send_req, tx_data}, {23'd0, 1'b1, 8'hED});
            end
        end
        check("t5_stall_req", {31'd0, send_req}, 32'd1);
        check("t5_stall_data", {24'd0, tx_data}, 32'hED);
        tx_ready = 1'b1;
        wait_accept("t5_cmd", 5);
        rx_byte(8'hFA);
        wait_accept("t5_arg", 5);
        rx_byte(8'h1C);
        repeat (3) tick();
        check("t5_ignored_busy", {31'd0, busy}, 32'd1);
        check("t5_ignored_req", {31'd0, send_req}, 32'd0);
        check("t5_ignored_leds", {29'd0, leds_applied}, 32'd6);
        rx_byte(8'hFA);
        check("t5_leds", {29'd0, leds_applied}, 32'd4);

        // Scenario 6: reset pulse during ACK_ARG
        status = 3'd7;
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h07);
        wait_accept("t6_cmd", 40);
        rx_byte(8'hFA);
        wait_accept("t6_arg", 5);
        reset = 1'b1;
        tick();
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_send_req", {31'd0, send_req}, 32'd0);
        check("t6_leds", {29'd0, leds_applied}, 32'd0);
        reset = 1'b0;
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h07);
        wait_accept("t6_restart_cmd", 40);
        rx_byte(8'hFA);
        wait_accept("t6_restart_arg", 5);
        rx_byte(8'hFA);
        check("t6_leds_new", {29'd0, leds_applied}, 32'd7);

        // Table-driven transactions
        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].st, vecs[i].arg);
            check($sformatf("vec%0d_leds", i), {29'd0, leds_applied}, {29'd0, vecs[i].leds});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
        end

        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_err_cnt", err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
